// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- handshaked, parametrised ALU with iterative unsigned
// multiply / divide / remainder and status flags. Holds one operation.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   issue stage presents an operation
//   in_ready   block accepts an operation this cycle
//   a, b       operands (WIDTH bits)
//   f          opcode (4 bits)
//   out_valid  result is held valid
//   out_ready  writeback stage takes the result
//   r          result (WIDTH bits)
//   zero       r == 0
//   ovf        signed overflow of ADD/SUB
//   dz         divide by zero (DIVU/REMU with b == 0)
//   err        illegal opcode
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             err
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_isDiv;
  logic             r_selHi;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dz;
  logic             r_err;

  logic             w_accept;
  logic             w_iter;
  logic             w_lastStep;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_dz;
  logic             w_err;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_remSh;
  logic [WIDTH-1:0] w_remSub;
  logic             w_ge;
  logic [WIDTH-1:0] w_stepHi;
  logic [WIDTH-1:0] w_stepLo;
  logic [WIDTH-1:0] w_finRes;

  assign w_accept   = in_valid && in_ready;
  assign w_lastStep = (r_cnt == CNTW'(WIDTH - 1));

  // Single-cycle results and classification of the incoming opcode.
  // Division by zero is resolved here so it never enters the iterator.
  always_comb begin
    w_sum  = a + b;
    w_diff = a - b;
    w_res  = '0;
    w_ovf  = 1'b0;
    w_dz   = 1'b0;
    w_err  = 1'b0;
    w_iter = 1'b0;
    case (f)
      4'b0000: w_res = a & b;
      4'b0001: w_res = a | b;
      4'b0010: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        w_res = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000, 4'b1001: w_iter = 1'b1;
      4'b1010: begin
        if (b == '0) begin
          w_res = '1;
          w_dz  = 1'b1;
        end else begin
          w_iter = 1'b1;
        end
      end
      4'b1011: begin
        if (b == '0) begin
          w_res = a;
          w_dz  = 1'b1;
        end else begin
          w_iter = 1'b1;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  // One iteration step. Multiply: {hi,lo} holds partial product and the
  // multiplier, shifted right each step. Divide: hi is the partial
  // remainder, lo shifts the dividend out and the quotient bits in.
  always_comb begin
    w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_remSh  = {r_hi, r_lo[WIDTH-1]};
    w_ge     = (w_remSh >= {1'b0, r_opnd});
    // When w_ge holds the true difference is below r_opnd, so it fits.
    w_remSub = w_remSh[WIDTH-1:0] - r_opnd;
    if (r_isDiv) begin
      w_stepHi = w_ge ? w_remSub : w_remSh[WIDTH-1:0];
      w_stepLo = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_stepHi = w_mulSum[WIDTH:1];
      w_stepLo = {w_mulSum[0], r_lo[WIDTH-1:1]};
    end
    w_finRes = r_selHi ? w_stepHi : w_stepLo;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state logic. DONE with a simultaneous transfer and accept
  // behaves like IDLE so single-cycle ops stream without bubbles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_nextState = w_iter ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (w_lastStep) w_nextState = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_nextState = w_accept ? (w_iter ? S_BUSY : S_DONE) : S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    out_valid = (r_state == S_DONE);
  end

  // Operand capture, iteration and result registers. The result only
  // changes on an accept or on the final iteration step, so it is stable
  // for as long as DONE is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_isDiv <= 1'b0;
      r_selHi <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= f[1] ? a : b;
      r_opnd  <= f[1] ? b : a;
      r_isDiv <= f[1];
      // MULHI and REMU take the high half, MULLO and DIVU the low half.
      r_selHi <= f[0];
      if (!w_iter) begin
        r_res  <= w_res;
        r_zero <= (w_res == '0);
        r_ovf  <= w_ovf;
        r_dz   <= w_dz;
        r_err  <= w_err;
      end
    end else if (r_state == S_BUSY) begin
      r_hi  <= w_stepHi;
      r_lo  <= w_stepLo;
      r_cnt <= r_cnt + CNTW'(1);
      if (w_lastStep) begin
        r_res  <= w_finRes;
        r_zero <= (w_finRes == '0);
        r_ovf  <= 1'b0;
        r_dz   <= 1'b0;
        r_err  <= 1'b0;
      end
    end
  end

  assign r    = r_res;
  assign zero = r_zero;
  assign ovf  = r_ovf;
  assign dz   = r_dz;
  assign err  = r_err;

endmodule
